// File: rtl/draw_bars_pkg.sv
// Shared constants, colours and the timing/pixel bus type for the draw-stage chain.
package draw_bars_pkg;

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned RGB_W     = 12;
    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned NUM_CHAN  = 13;

    localparam int unsigned DEF_BAR_X0      = 64;
    localparam int unsigned DEF_BAR_PITCH   = 56;
    localparam int unsigned DEF_BAR_W       = 40;
    localparam int unsigned DEF_BASE_Y      = 560;
    localparam int unsigned DEF_SCALE_SHIFT = 4;

    localparam logic [SAMPLE_W-1:0] DEF_LIMIT   = 12'hC00;
    localparam logic [RGB_W-1:0]    COLOR_GREEN = 12'h0F0;
    localparam logic [RGB_W-1:0]    COLOR_RED   = 12'hF00;

    // Timing counters, strobes and pixel colour travelling between draw stages.
    typedef struct packed {
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [RGB_W-1:0] rgb;
    } vga_bus_t;

    function automatic logic [SAMPLE_W-1:0] bar_height(
        input logic [SAMPLE_W-1:0] sample,
        input int unsigned         shift
    );
        return sample >> shift;
    endfunction

endpackage

// File: rtl/draw_bars_bar_regs.sv
// Double-buffered channel sample store: writes land in pending, copied to active
// on each rising edge of vertical blanking so a frame never sees a torn update.
module bar_regs
    import draw_bars_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [SAMPLE_W-1:0] data_i,
    input  logic                vblnk_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic [SAMPLE_W-1:0] rd_data_c_o
);

    logic [SAMPLE_W-1:0] pending_q [NUM_CHAN];
    logic [SAMPLE_W-1:0] active_q  [NUM_CHAN];
    logic                vblnk_q;
    logic                commit_c;

    assign commit_c = vblnk_i & ~vblnk_q;

    // Commit reads pending before the same-cycle write lands, deferring it a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vblnk_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_CHAN; i++) begin
                pending_q[i] <= '0;
                active_q[i]  <= '0;
            end
        end else begin
            vblnk_q <= vblnk_i;
            if (commit_c) begin
                for (int unsigned i = 0; i < NUM_CHAN; i++) begin
                    active_q[i] <= pending_q[i];
                end
            end
            if (we_i && (idx_i < IDX_W'(NUM_CHAN))) begin
                pending_q[idx_i] <= data_i;
            end
        end
    end

    assign rd_data_c_o = (rd_idx_i < IDX_W'(NUM_CHAN)) ? active_q[rd_idx_i] : '0;

endmodule

// File: rtl/draw_bars.sv
// Bar-graph overlay stage: tracks bar columns with counters (no divider) and
// composites per-channel bars over the upstream pixel, two cycles of latency.
module draw_bars
    import draw_bars_pkg::*;
#(
    parameter int unsigned          BAR_X0      = DEF_BAR_X0,
    parameter int unsigned          BAR_PITCH   = DEF_BAR_PITCH,
    parameter int unsigned          BAR_W       = DEF_BAR_W,
    parameter int unsigned          BASE_Y      = DEF_BASE_Y,
    parameter int unsigned          SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter logic [SAMPLE_W-1:0]  LIMIT       = DEF_LIMIT,
    parameter logic [RGB_W-1:0]     BAR_COLOR   = COLOR_GREEN,
    parameter logic [RGB_W-1:0]     ALARM_COLOR = COLOR_RED
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic [CNT_W-1:0]    vcount_in,
    input  logic [CNT_W-1:0]    hcount_in,
    input  logic                vsync_in,
    input  logic                vblnk_in,
    input  logic                hsync_in,
    input  logic                hblnk_in,
    input  logic [RGB_W-1:0]    rgb_in,
    input  logic                chan_we,
    input  logic [IDX_W-1:0]    chan_idx,
    input  logic [SAMPLE_W-1:0] chan_data,
    output logic [CNT_W-1:0]    vcount_out,
    output logic [CNT_W-1:0]    hcount_out,
    output logic                vsync_out,
    output logic                vblnk_out,
    output logic                hsync_out,
    output logic                hblnk_out,
    output logic [RGB_W-1:0]    rgb_out
);

    localparam int unsigned     PX_W     = (BAR_PITCH > 1) ? $clog2(BAR_PITCH) : 1;
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_CHAN - 1);

    vga_bus_t            bus_in;
    vga_bus_t            s1_q;
    vga_bus_t            s2_q;
    vga_bus_t            s2_d;
    logic [PX_W-1:0]     px_q;
    logic [PX_W-1:0]     px_d;
    logic [IDX_W-1:0]    col_q;
    logic [IDX_W-1:0]    col_d;
    logic                in_region_q;
    logic                in_region_d;
    logic [SAMPLE_W-1:0] sample_c;
    logic [SAMPLE_W-1:0] height_c;
    logic [CNT_W-1:0]    depth_c;
    logic                in_bar_c;

    assign bus_in = '{vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                      hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                      rgb: rgb_in};

    bar_regs u_bar_regs (
        .clk_i       (pclk),
        .rst_ni      (rst),
        .we_i        (chan_we),
        .idx_i       (chan_idx),
        .data_i      (chan_data),
        .vblnk_i     (vblnk_in),
        .rd_idx_i    (col_q),
        .rd_data_c_o (sample_c)
    );

    // Stage 1: pixel-within-pitch and column counters, restarted at the left edge.
    always_comb begin
        px_d        = px_q;
        col_d       = col_q;
        in_region_d = in_region_q;
        if (hblnk_in) begin
            in_region_d = 1'b0;
        end else if (hcount_in == CNT_W'(BAR_X0)) begin
            px_d        = '0;
            col_d       = '0;
            in_region_d = 1'b1;
        end else if (in_region_q) begin
            if (px_q == PX_W'(BAR_PITCH - 1)) begin
                px_d = '0;
                if (col_q == LAST_COL) begin
                    in_region_d = 1'b0;
                end else begin
                    col_d = col_q + IDX_W'(1);
                end
            end else begin
                px_d = px_q + PX_W'(1);
            end
        end
    end

    // Stage 2: bar hit test against the counters registered with px/col.
    always_comb begin
        height_c = bar_height(sample_c, SCALE_SHIFT);
        depth_c  = CNT_W'(BASE_Y) - s1_q.vcount;
        in_bar_c = in_region_q
                && (px_q < PX_W'(BAR_W))
                && (s1_q.vcount <= CNT_W'(BASE_Y))
                && (depth_c < height_c);
        s2_d     = s1_q;
        if (!s1_q.hblnk && !s1_q.vblnk && in_bar_c) begin
            s2_d.rgb = (sample_c >= LIMIT) ? ALARM_COLOR : BAR_COLOR;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            px_q        <= '0;
            col_q       <= '0;
            in_region_q <= 1'b0;
        end else begin
            s1_q        <= bus_in;
            s2_q        <= s2_d;
            px_q        <= px_d;
            col_q       <= col_d;
            in_region_q <= in_region_d;
        end
    end

    assign vcount_out = s2_q.vcount;
    assign hcount_out = s2_q.hcount;
    assign vsync_out  = s2_q.vsync;
    assign vblnk_out  = s2_q.vblnk;
    assign hsync_out  = s2_q.hsync;
    assign hblnk_out  = s2_q.hblnk;
    assign rgb_out    = s2_q.rgb;

endmodule

// File: tb/tb_draw_bars.sv
// Directed bench for draw_bars: pixel-by-pixel compare against a geometric reference.
module tb_draw_bars;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] vcount_in, hcount_in, rgb_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic        chan_we;
    logic [3:0]  chan_idx;
    logic [11:0] chan_data;
    logic [11:0] vcount_out, hcount_out, rgb_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [11:0] m_pend [13];
    logic [11:0] m_act  [13];
    logic        m_prev_vb;
    logic        have_prev;
    logic [11:0] prev_rgb;
    logic [27:0] prev_tim;
    string       prev_tag;

    always #5 pclk = ~pclk;

    draw_bars dut (
        .pclk       (pclk),
        .rst        (rst),
        .vcount_in  (vcount_in),
        .hcount_in  (hcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .rgb_in     (rgb_in),
        .chan_we    (chan_we),
        .chan_idx   (chan_idx),
        .chan_data  (chan_data),
        .vcount_out (vcount_out),
        .hcount_out (hcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .rgb_out    (rgb_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: bars at x=64+56*c .. +39, bottom line 560, height sample>>4.
    function automatic logic [11:0] model_rgb(input int v, input int h, input logic hb,
                                              input logic vb, input logic [11:0] rgb);
        int off, col, hh;
        if (hb || vb) return rgb;
        if (h < 64 || h >= 64 + 13 * 56) return rgb;
        off = h - 64;
        col = off / 56;
        if ((off % 56) >= 40) return rgb;
        hh = int'(m_act[col] >> 4);
        if (v > 560) return rgb;
        if ((560 - v) >= hh) return rgb;
        return (m_act[col] >= 12'hC00) ? 12'hF00 : 12'h0F0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 13; i++) begin
            m_pend[i] = '0;
            m_act[i]  = '0;
        end
        m_prev_vb = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic step(input int v, input int h, input logic hb, input logic vb,
                        input logic we, input logic [3:0] idx, input logic [11:0] data);
        logic [11:0] rgb;
        logic        vs, hs;
        rgb = 12'($urandom);
        vs  = 1'($urandom);
        hs  = 1'($urandom);
        vcount_in = 12'(v);
        hcount_in = 12'(h);
        vsync_in  = vs;
        hsync_in  = hs;
        vblnk_in  = vb;
        hblnk_in  = hb;
        rgb_in    = rgb;
        chan_we   = we;
        chan_idx  = idx;
        chan_data = data;
        if (vb && !m_prev_vb) begin
            for (int i = 0; i < 13; i++) m_act[i] = m_pend[i];
        end
        m_prev_vb = vb;
        if (we && idx <= 4'd12) m_pend[idx] = data;
        @(posedge pclk);
        #1;
        if (have_prev) begin
            check({prev_tag, " rgb"}, 64'(rgb_out), 64'(prev_rgb));
            check({prev_tag, " timing"},
                  64'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}),
                  64'(prev_tim));
        end
        prev_rgb  = model_rgb(v, h, hb, vb, rgb);
        prev_tim  = {12'(v), vs, vb, 12'(h), hs, hb};
        prev_tag  = $sformatf("v%0d h%0d", v, h);
        have_prev = 1'b1;
    endtask

    task automatic scan(input int v, input int h_last);
        for (int h = 60; h <= h_last; h++) step(v, h, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [11:0] data);
        step(0, 0, 1'b1, 1'b0, 1'b1, idx, data);
    endtask

    task automatic vblank(input logic we, input logic [3:0] idx, input logic [11:0] data);
        step(600, 0, 1'b1, 1'b1, we, idx, data);
        step(601, 0, 1'b1, 1'b1, 1'b0, 4'd0, 12'd0);
        step(602, 0, 1'b1, 1'b1, 1'b0, 4'd0, 12'd0);
        step(0,   0, 1'b1, 1'b0, 1'b0, 4'd0, 12'd0);
    endtask

    initial begin
        rst       = 1'b0;
        vcount_in = 12'h123;
        hcount_in = 12'h045;
        vsync_in  = 1'b1;
        vblnk_in  = 1'b0;
        hsync_in  = 1'b1;
        hblnk_in  = 1'b0;
        rgb_in    = 12'hABC;
        chan_we   = 1'b0;
        chan_idx  = 4'd0;
        chan_data = 12'd0;
        model_reset();
        prev_rgb  = '0;
        prev_tim  = '0;
        prev_tag  = "";

        @(posedge pclk);
        @(posedge pclk);
        #1;
        check("reset outputs", 64'({vcount_out, hcount_out, vsync_out, vblnk_out,
                                    hsync_out, hblnk_out, rgb_out}), 64'd0);
        rst = 1'b1;

        // No writes yet: nothing drawn.
        vblank(1'b0, 4'd0, 12'd0);
        scan(500, 800);

        // ch0 = 0x640 -> h=100, lines 461..560.
        wr(4'd0, 12'h640);
        scan(460, 120);
        vblank(1'b0, 4'd0, 12'd0);
        scan(460, 120);
        scan(461, 120);
        scan(560, 120);
        scan(561, 120);

        // ch12 full scale (alarm) and ch7 exactly at the limit.
        wr(4'd12, 12'hFFF);
        wr(4'd7,  12'hC00);
        vblank(1'b0, 4'd0, 12'd0);
        scan(305, 800);
        scan(306, 800);
        scan(369, 800);
        wr(4'd12, 12'hBFF);
        vblank(1'b0, 4'd0, 12'd0);
        scan(369, 800);
        scan(370, 800);

        // Mid-frame write stays hidden until the next commit.
        scan(540, 300);
        wr(4'd3, 12'h200);
        scan(540, 300);
        vblank(1'b0, 4'd0, 12'd0);
        scan(540, 300);

        // Write on the commit cycle itself lands a frame later.
        vblank(1'b1, 4'd5, 12'h300);
        scan(530, 400);
        vblank(1'b0, 4'd0, 12'd0);
        scan(530, 400);

        // Out-of-range index ignored; h=0 draws nothing.
        wr(4'd13, 12'hFFF);
        wr(4'd0,  12'h00F);
        vblank(1'b0, 4'd0, 12'd0);
        scan(560, 800);

        // Horizontal blanking masks bars even at the bar's left edge.
        for (int h = 60; h <= 110; h++) step(540, h, 1'b1, 1'b0, 1'b0, 4'd0, 12'd0);

        // Asynchronous reset mid-line.
        for (int h = 60; h <= 300; h++) step(540, h, 1'b0, 1'b0, 1'b0, 4'd0, 12'd0);
        #3;
        rst = 1'b0;
        #1;
        check("async reset outputs", 64'({vcount_out, hcount_out, vsync_out, vblnk_out,
                                          hsync_out, hblnk_out, rgb_out}), 64'd0);
        @(posedge pclk);
        #1;
        check("held reset outputs", 64'({vcount_out, hcount_out, vsync_out, vblnk_out,
                                         hsync_out, hblnk_out, rgb_out}), 64'd0);
        model_reset();
        rst = 1'b1;

        // Two frames after reset with no writes: only rgb_in.
        vblank(1'b0, 4'd0, 12'd0);
        scan(540, 800);
        vblank(1'b0, 4'd0, 12'd0);
        scan(540, 800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
